// File: rtl/refresh_scheduler.sv
`timescale 1ns/1ps
// Purpose: sequences the periodic shift-refresh of the 8-bank gain-cell array by
//   copying every row of bank swap_index into spare slot 0, then pulsing any_ref_done.
// Latency: a started refresh reaches any_ref_done 2*ROWS+1 cycles after its start cycle.
// Backpressure: host_ready drops from the start cycle through DONE; a due refresh
//   yields to host_req for at most MAX_POSTPONE cycles, then it is forced.
// Ports:
//   clk, rst (async, active-low)   clock and reset
//   host_req / host_ready          host access handshake (accepted when both are 1)
//   ref_busy                       copy in progress, controller routes cp_* to the array
//   cp_raddr/cp_waddr/cp_row       copy source slot, destination slot (always 0), row
//   cp_rd_en/cp_wr_en              copy read / copy write strobes (never both 1)
//   any_ref_done                   one-cycle completion pulse for the shift address table
//   ref_mem_addr                   current swap_index
//   ref_miss                       sticky: a refresh tick was dropped
module refresh_scheduler #(
  parameter int REF_INTERVAL = 64,
  parameter int ROWS         = 4,
  parameter int ROW_W        = 2,
  parameter int MAX_POSTPONE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             host_req,
  output logic             host_ready,
  output logic             ref_busy,
  output logic [2:0]       cp_raddr,
  output logic [2:0]       cp_waddr,
  output logic [ROW_W-1:0] cp_row,
  output logic             cp_rd_en,
  output logic             cp_wr_en,
  output logic             any_ref_done,
  output logic [2:0]       ref_mem_addr,
  output logic             ref_miss
);

  localparam int CNT_W = $clog2(REF_INTERVAL);
  localparam int PP_W  = $clog2(MAX_POSTPONE + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  int_cnt;
  logic [PP_W-1:0]   postpone;
  logic              pending;
  logic [2:0]        swap_index;
  logic [ROW_W-1:0]  row;

  logic tick;
  logic start;
  logic copying;
  logic last_row;

  assign tick     = (int_cnt == CNT_W'(REF_INTERVAL - 1));
  assign copying  = (state == RD) || (state == WR);
  assign last_row = (row == ROW_W'(ROWS - 1));
  // Host wins a same-cycle conflict until the postpone budget is exhausted.
  assign start    = (state == IDLE) && pending &&
                    (!host_req || (postpone == PP_W'(MAX_POSTPONE)));

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RD;
      RD:      state_nxt = WR;
      WR:      state_nxt = last_row ? DONE : RD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    host_ready   = 1'b0;
    ref_busy     = 1'b0;
    cp_raddr     = 3'd0;
    cp_waddr     = 3'd0;
    cp_row       = '0;
    cp_rd_en     = 1'b0;
    cp_wr_en     = 1'b0;
    any_ref_done = 1'b0;
    case (state)
      IDLE: host_ready = !start;
      RD: begin
        ref_busy = 1'b1;
        cp_rd_en = 1'b1;
        cp_row   = row;
        cp_raddr = swap_index;
      end
      WR: begin
        ref_busy = 1'b1;
        cp_wr_en = 1'b1;
        cp_row   = row;
        cp_raddr = swap_index;
      end
      DONE:    any_ref_done = 1'b1;
      default: host_ready = 1'b0;
    endcase
  end

  assign ref_mem_addr = swap_index;

  // ---------------- interval counter (free-running in every state) ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_cnt <= '0;
    end else if (tick) begin
      int_cnt <= '0;
    end else begin
      int_cnt <= int_cnt + CNT_W'(1);
    end
  end

  // ---------------- pending flag and miss detection ----------------
  // A tick that lands while a refresh is already pending or mid-copy is dropped
  // and recorded in ref_miss rather than queued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending  <= 1'b0;
      ref_miss <= 1'b0;
    end else begin
      if (start) begin
        pending <= 1'b0;
      end else if (tick && !copying) begin
        pending <= 1'b1;
      end
      if (tick && (pending || copying)) begin
        ref_miss <= 1'b1;
      end
    end
  end

  // ---------------- postpone counter ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      postpone <= '0;
    end else if (start) begin
      postpone <= '0;
    end else if ((state == IDLE) && pending && (postpone != PP_W'(MAX_POSTPONE))) begin
      postpone <= postpone + PP_W'(1);
    end
  end

  // ---------------- row counter ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
    end else if (start) begin
      row <= '0;
    end else if ((state == WR) && !last_row) begin
      row <= row + ROW_W'(1);
    end
  end

  // ---------------- swap index ----------------
  // Walks 1,7,6,...,2,1 in lockstep with the shift address table; slot 0 is the
  // spare and is never a copy source.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      swap_index <= 3'd1;
    end else if (state == DONE) begin
      swap_index <= (swap_index == 3'd1) ? 3'd7 : (swap_index - 3'd1);
    end
  end

endmodule

// File: tb/tb_refresh_scheduler.sv
`timescale 1ns/1ps
module tb_refresh_scheduler;

  localparam int ROWS = 4;

  logic clk;
  logic rst;
  logic host_req;
  logic host_req_m;

  logic       host_ready, ref_busy, cp_rd_en, cp_wr_en, any_ref_done, ref_miss;
  logic [2:0] cp_raddr, cp_waddr, ref_mem_addr;
  logic [1:0] cp_row;

  logic       host_ready_m, ref_busy_m, cp_rd_en_m, cp_wr_en_m, any_ref_done_m, ref_miss_m;
  logic [2:0] cp_raddr_m, cp_waddr_m, ref_mem_addr_m;
  logic [1:0] cp_row_m;

  refresh_scheduler dut (
    .clk(clk), .rst(rst), .host_req(host_req), .host_ready(host_ready),
    .ref_busy(ref_busy), .cp_raddr(cp_raddr), .cp_waddr(cp_waddr), .cp_row(cp_row),
    .cp_rd_en(cp_rd_en), .cp_wr_en(cp_wr_en), .any_ref_done(any_ref_done),
    .ref_mem_addr(ref_mem_addr), .ref_miss(ref_miss)
  );

  // Short interval instance so a tick lands while a forced refresh is copying.
  refresh_scheduler #(.REF_INTERVAL(12)) dut_m (
    .clk(clk), .rst(rst), .host_req(host_req_m), .host_ready(host_ready_m),
    .ref_busy(ref_busy_m), .cp_raddr(cp_raddr_m), .cp_waddr(cp_waddr_m), .cp_row(cp_row_m),
    .cp_rd_en(cp_rd_en_m), .cp_wr_en(cp_wr_en_m), .any_ref_done(any_ref_done_m),
    .ref_mem_addr(ref_mem_addr_m), .ref_miss(ref_miss_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  int          cyc;
  logic [16:0] sb[$];
  logic [16:0] exp_v;
  logic [16:0] obs_v;

  // {host_ready, ref_busy, rd, wr, row[1:0], raddr[2:0], waddr[2:0], done, mem[2:0], miss}
  function automatic logic [16:0] obs_main();
    return {host_ready, ref_busy, cp_rd_en, cp_wr_en, cp_row, cp_raddr, cp_waddr,
            any_ref_done, ref_mem_addr, ref_miss};
  endfunction

  function automatic logic [16:0] obs_m();
    return {host_ready_m, ref_busy_m, cp_rd_en_m, cp_wr_en_m, cp_row_m, cp_raddr_m, cp_waddr_m,
            any_ref_done_m, ref_mem_addr_m, ref_miss_m};
  endfunction

  function automatic logic [2:0] next_swap(input logic [2:0] m);
    return (m == 3'd1) ? 3'd7 : m - 3'd1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Called at posedge+1; releases reset at posedge+3 so the bench sits in cycle 0.
  task automatic do_reset();
    rst        = 1'b0;
    host_req   = 1'b0;
    host_req_m = 1'b0;
    sb.delete();
    #2;
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic push_idle(input int n, input logic [2:0] mem, input logic miss);
    for (int i = 0; i < n; i++)
      sb.push_back({1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 1'b0, mem, miss});
  endtask

  // Start cycle, ROWS read/write pairs from slot mem into slot 0, then the DONE pulse.
  task automatic push_refresh(input logic [2:0] mem, input logic miss);
    sb.push_back({1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 1'b0, mem, miss});
    for (int r = 0; r < ROWS; r++) begin
      sb.push_back({1'b0, 1'b1, 1'b1, 1'b0, 2'(r), mem, 3'd0, 1'b0, mem, miss});
      sb.push_back({1'b0, 1'b1, 1'b0, 1'b1, 2'(r), mem, 3'd0, 1'b0, mem, miss});
    end
    sb.push_back({1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 1'b1, mem, miss});
  endtask

  task automatic test_reset();
    do_reset();
    push_idle(10, 3'd1, 1'b0);
    while (sb.size() > 0) begin
      exp_v = sb.pop_front();
      obs_v = obs_main();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL reset cycle %0d: got %h expected %h", cyc, obs_v, exp_v);
      end
      obs_v = obs_m();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL reset_m cycle %0d: got %h expected %h", cyc, obs_v, exp_v);
      end
      step();
    end
  endtask

  task automatic test_basic();
    do_reset();
    push_idle(64, 3'd1, 1'b0);
    push_refresh(3'd1, 1'b0);
    push_idle(4, 3'd7, 1'b0);
    while (sb.size() > 0) begin
      exp_v = sb.pop_front();
      obs_v = obs_main();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL basic cycle %0d: got %h expected %h", cyc, obs_v, exp_v);
      end
      step();
    end
  endtask

  // Host holds the array from cycle 60; the refresh is forced once postpone hits 8 (cycle 72).
  task automatic test_contention();
    do_reset();
    push_idle(72, 3'd1, 1'b0);
    push_refresh(3'd1, 1'b0);
    push_idle(3, 3'd7, 1'b0);
    while (sb.size() > 0) begin
      if (cyc == 60) host_req = 1'b1;
      #1;
      exp_v = sb.pop_front();
      obs_v = obs_main();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL contention cycle %0d: got %h expected %h", cyc, obs_v, exp_v);
      end
      step();
    end
    host_req = 1'b0;
  endtask

  // At cycle 67 postpone is 3: host is accepted. Dropping host_req at 68 starts refresh at once.
  task automatic test_tie_break();
    do_reset();
    push_idle(68, 3'd1, 1'b0);
    push_refresh(3'd1, 1'b0);
    push_idle(2, 3'd7, 1'b0);
    while (sb.size() > 0) begin
      if (cyc == 60) host_req = 1'b1;
      if (cyc == 68) host_req = 1'b0;
      #1;
      exp_v = sb.pop_front();
      obs_v = obs_main();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL tie_break cycle %0d: got %h expected %h", cyc, obs_v, exp_v);
      end
      step();
    end
  endtask

  task automatic test_wrap();
    logic [2:0] m;
    do_reset();
    m = 3'd1;
    push_idle(64, m, 1'b0);
    for (int k = 0; k < 8; k++) begin
      push_refresh(m, 1'b0);
      m = next_swap(m);
      push_idle(54, m, 1'b0);
    end
    while (sb.size() > 0) begin
      exp_v = sb.pop_front();
      obs_v = obs_main();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL wrap cycle %0d: got %h expected %h", cyc, obs_v, exp_v);
      end
      step();
    end
    checks++;
    if (ref_mem_addr !== 3'd7) begin
      errors++;
      $display("FAIL wrap_final: got %0d expected 7", ref_mem_addr);
    end
  endtask

  // REF_INTERVAL=12 with the host always requesting: forced refresh at 20..29, the tick at
  // cycle 23 lands mid-copy so ref_miss rises at cycle 24 and stays set.
  task automatic test_miss();
    logic exp_miss;
    do_reset();
    host_req_m = 1'b1;
    push_idle(20, 3'd1, 1'b0);
    push_refresh(3'd1, 1'b0);
    push_idle(14, 3'd7, 1'b0);
    push_refresh(3'd7, 1'b0);
    push_idle(2, 3'd6, 1'b0);
    while (sb.size() > 0) begin
      exp_v    = sb.pop_front();
      exp_miss = (cyc >= 24);
      obs_v    = obs_m();
      checks++;
      if (obs_v[16:1] !== exp_v[16:1]) begin
        errors++;
        $display("FAIL miss_seq cycle %0d: got %h expected %h", cyc, obs_v[16:1], exp_v[16:1]);
      end
      checks++;
      if (obs_v[0] !== exp_miss) begin
        errors++;
        $display("FAIL miss_flag cycle %0d: got %b expected %b", cyc, obs_v[0], exp_miss);
      end
      step();
    end
    do_reset();
    checks++;
    if (ref_miss_m !== 1'b0) begin
      errors++;
      $display("FAIL miss_cleared: got %b expected 0", ref_miss_m);
    end
  endtask

  // Reset asserted during WR of row 2 (cycle 70): outputs drop immediately, no DONE follows.
  task automatic test_reset_midcopy();
    do_reset();
    push_idle(64, 3'd1, 1'b0);
    push_refresh(3'd1, 1'b0);
    for (int i = 0; i < 70; i++) begin
      exp_v = sb.pop_front();
      obs_v = obs_main();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL midcopy_pre cycle %0d: got %h expected %h", cyc, obs_v, exp_v);
      end
      step();
    end
    exp_v = sb.pop_front();
    obs_v = obs_main();
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL midcopy_wr2 cycle %0d: got %h expected %h", cyc, obs_v, exp_v);
    end
    rst = 1'b0;
    #1;
    obs_v = obs_main();
    checks++;
    if (obs_v !== {1'b1, 12'd0, 3'd1, 1'b0}) begin
      errors++;
      $display("FAIL midcopy_async: got %h expected %h", obs_v, {1'b1, 12'd0, 3'd1, 1'b0});
    end
    sb.delete();
    #1;
    rst = 1'b1;
    cyc = 0;
    push_idle(20, 3'd1, 1'b0);
    while (sb.size() > 0) begin
      exp_v = sb.pop_front();
      obs_v = obs_main();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL midcopy_post cycle %0d: got %h expected %h", cyc, obs_v, exp_v);
      end
      step();
    end
  endtask

  initial begin
    rst        = 1'b0;
    host_req   = 1'b0;
    host_req_m = 1'b0;
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_contention();
    test_tie_break();
    test_wrap();
    test_miss();
    test_reset_midcopy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
